// File: rtl/y_mc_ctrl_if.sv
// y_mc_ctrl_if: control-sequencer bundle between the yIF/yID/yEX/yDM/yWB
// datapath and y_mc_ctrl.
//   master : datapath side; drives start/stop, instruction word, ALU zero
//            flag and data-memory ready; observes every control line.
//   slave  : sequencer side (y_mc_ctrl); the mirror image.
// Signals:
//   start, stop, ins[31:0], zero, mem_ready          datapath -> sequencer
//   ir_we, RegDst, ALUSrc, Mem2Reg, RegWrite,
//   MemRead, MemWrite, op[2:0], pc_sel[1:0], pc_we,
//   retired[CNT_W-1:0], busy, illegal, done          sequencer -> datapath
interface y_mc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             ir_we;
  logic             RegDst;
  logic             ALUSrc;
  logic             Mem2Reg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       op;
  logic [1:0]       pc_sel;
  logic             pc_we;
  logic [CNT_W-1:0] retired;
  logic             busy;
  logic             illegal;
  logic             done;

  modport master (
    output start, stop, ins, zero, mem_ready,
    input  ir_we, RegDst, ALUSrc, Mem2Reg, RegWrite, MemRead, MemWrite,
    input  op, pc_sel, pc_we, retired, busy, illegal, done
  );

  modport slave (
    input  start, stop, ins, zero, mem_ready,
    output ir_we, RegDst, ALUSrc, Mem2Reg, RegWrite, MemRead, MemWrite,
    output op, pc_sel, pc_we, retired, busy, illegal, done
  );
endinterface

// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB
// MIPS-subset datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives mux selects, enables, ALU op and the
// PC load, stalls on data-memory readiness, counts retired instructions
// and halts on an illegal encoding or when the retire budget is reached.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    y_mc_ctrl_if.slave (see interface file for the signal list)
// Parameters:
//   CNT_W      width of the retired-instruction counter
//   MAX_INSTR  retire budget, 0 = unlimited
module y_mc_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  y_mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_BAD
  } cls_t;

  state_t           state;
  logic [5:0]       opcode_q;
  logic [5:0]       funct_q;
  logic             regdst_q;
  logic             alusrc_q;
  logic             mem2reg_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             stop_pend;
  logic             illegal_q;
  logic             done_q;

  cls_t             cls;
  logic             ir_we_w;
  logic             regwrite_w;
  logic             memread_w;
  logic             memwrite_w;
  logic             pc_we_w;
  logic [1:0]       pc_sel_w;
  logic             busy_w;
  logic [CNT_W-1:0] cnt_next;
  logic             budget_hit;
  logic             stop_now;
  state_t           retire_state;

  function automatic cls_t decode_cls(input logic [5:0] opcode,
                                      input logic [5:0] funct);
    cls_t c;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24, 6'h25, 6'h20, 6'h22, 6'h2a: c = C_RTYPE;
          default:                           c = C_BAD;
        endcase
      end
      6'h08:   c = C_ADDI;
      6'h23:   c = C_LW;
      6'h2b:   c = C_SW;
      6'h04:   c = C_BEQ;
      6'h02:   c = C_J;
      default: c = C_BAD;
    endcase
    return c;
  endfunction

  // Packed as {RegDst, ALUSrc, Mem2Reg, op}.
  function automatic logic [5:0] decode_mux(input cls_t c,
                                            input logic [5:0] funct);
    logic [5:0] m;
    case (c)
      C_RTYPE: begin
        case (funct)
          6'h24:   m = {3'b100, 3'b000};
          6'h25:   m = {3'b100, 3'b001};
          6'h20:   m = {3'b100, 3'b010};
          6'h22:   m = {3'b100, 3'b110};
          default: m = {3'b100, 3'b111};
        endcase
      end
      C_ADDI:  m = {3'b010, 3'b010};
      C_LW:    m = {3'b011, 3'b010};
      C_SW:    m = {3'b010, 3'b010};
      C_BEQ:   m = {3'b000, 3'b110};
      default: m = {3'b000, 3'b010};
    endcase
    return m;
  endfunction

  // Class comes from the fields latched in FETCH, so nothing downstream
  // depends combinationally on ins.
  assign cls = decode_cls(opcode_q, funct_q);

  assign busy_w       = (state != S_IDLE) && (state != S_HALT);
  assign cnt_next     = retired_q + 1'b1;
  assign budget_hit   = (MAX_INSTR != 0) && (cnt_next == CNT_W'(MAX_INSTR));
  // A stop arriving in the retiring cycle itself still counts as pending.
  assign stop_now     = stop_pend | bus.stop;
  assign retire_state = budget_hit ? S_HALT : (stop_now ? S_IDLE : S_FETCH);

  always_comb begin
    ir_we_w    = 1'b0;
    regwrite_w = 1'b0;
    memread_w  = 1'b0;
    memwrite_w = 1'b0;
    pc_we_w    = 1'b0;
    pc_sel_w   = 2'b00;
    case (state)
      S_FETCH: ir_we_w = 1'b1;
      S_DECODE: begin
        if (cls == C_J) begin
          pc_we_w  = 1'b1;
          pc_sel_w = 2'b10;
        end
      end
      S_EXEC: begin
        if (cls == C_BEQ) begin
          pc_we_w  = 1'b1;
          pc_sel_w = {1'b0, bus.zero};
        end
      end
      S_MEM: begin
        memread_w  = (cls == C_LW);
        memwrite_w = (cls == C_SW);
        pc_we_w    = (cls == C_SW) && bus.mem_ready;
      end
      S_WB: begin
        regwrite_w = 1'b1;
        pc_we_w    = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction fields are datapath values: captured on every FETCH,
  // meaningless until then, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      opcode_q <= bus.ins[31:26];
      funct_q  <= bus.ins[5:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      regdst_q  <= 1'b0;
      alusrc_q  <= 1'b0;
      mem2reg_q <= 1'b0;
      op_q      <= 3'b000;
      retired_q <= '0;
      stop_pend <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (busy_w && bus.stop) stop_pend <= 1'b1;
      case (state)
        S_IDLE:   if (bus.start) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (cls == C_BAD) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            {regdst_q, alusrc_q, mem2reg_q, op_q} <= decode_mux(cls, funct_q);
            if (cls != C_J) state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls == C_LW || cls == C_SW) state <= S_MEM;
          else if (cls != C_BEQ)          state <= S_WB;
        end
        S_MEM:  if (bus.mem_ready && cls == C_LW) state <= S_WB;
        default: ;
      endcase
      // Every retiring cycle ends here; this later assignment overrides
      // the per-state next state chosen above.
      if (pc_we_w) begin
        retired_q <= cnt_next;
        state     <= retire_state;
        if (budget_hit)    done_q    <= 1'b1;
        else if (stop_now) stop_pend <= 1'b0;
      end
    end
  end

  assign bus.ir_we    = ir_we_w;
  assign bus.RegDst   = regdst_q;
  assign bus.ALUSrc   = alusrc_q;
  assign bus.Mem2Reg  = mem2reg_q;
  assign bus.RegWrite = regwrite_w;
  assign bus.MemRead  = memread_w;
  assign bus.MemWrite = memwrite_w;
  assign bus.op       = op_q;
  assign bus.pc_sel   = pc_sel_w;
  assign bus.pc_we    = pc_we_w;
  assign bus.retired  = retired_q;
  assign bus.busy     = busy_w;
  assign bus.illegal  = illegal_q;
  assign bus.done     = done_q;

endmodule
